// File: rtl/vector_lsu.sv
// vector_lsu: unit-stride vector load/store unit between the OBI data port and the vector register file.
// Latency (zero-wait bus): load 1 + 2*words + 2 cycles start-to-done inclusive, store 1 + 2*words + 1.
// Backpressure: one OBI transaction outstanding; request fields held until data_gnt_i; start ignored unless idle.
//
// Ports: clk/n_reset (async active-low); start/store/base_addr/vl/vsew/vs3_data request from the decoder;
//        busy/done/error status; vd_data/vreg_write/elements_to_write register-file write port;
//        data_* OBI master port.
// Optional: define VLSU_BUS_ERR_EN to add data_err_i; an error response aborts the transfer with error.
module vector_lsu #(
  parameter int VLEN       = 128,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  start,
  input  logic                  store,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [4:0]            vl,
  input  logic [1:0]            vsew,
  input  logic [VLEN-1:0]       vs3_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [VLEN-1:0]       vd_data,
  output logic                  vreg_write,
  output logic [4:0]            elements_to_write,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  output logic [ADDR_WIDTH-1:0] data_addr_o,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [31:0]           data_wdata_o,
  input  logic                  data_rvalid_i,
`ifdef VLSU_BUS_ERR_EN
  input  logic                  data_err_i,
`endif
  input  logic [31:0]           data_rdata_i
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_WB   = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [2:0]            words_q, words_d;
  logic [1:0]            rem_q, rem_d;
  logic                  store_q, store_d;
  logic                  err_q, err_d;
  logic [4:0]            vl_q, vl_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [VLEN-1:0]       buf_q, buf_d;
  logic [VLEN-1:0]       vd_q, vd_d;

  // Transfer size: vsew=11 behaves as 32-bit elements, total capped at one register.
  logic [1:0] sew_eff;
  logic [6:0] bytes_raw;
  logic [4:0] bytes_cap;

  assign sew_eff   = (vsew == 2'b11) ? 2'b10 : vsew;
  assign bytes_raw = {2'b00, vl} << sew_eff;
  assign bytes_cap = (bytes_raw > 7'd16) ? 5'd16 : bytes_raw[4:0];

  // Only the final word can be partial; a zero remainder means it is full.
  logic       last_word;
  logic [3:0] be;

  assign last_word = ({1'b0, idx_q} == (words_q - 3'd1));

  always_comb begin
    be = 4'b1111;
    if (last_word) begin
      case (rem_q)
        2'd1:    be = 4'b0001;
        2'd2:    be = 4'b0011;
        2'd3:    be = 4'b0111;
        default: be = 4'b1111;
      endcase
    end
  end

  logic rsp_err;
`ifdef VLSU_BUS_ERR_EN
  assign rsp_err = data_err_i;
`else
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    words_d = words_q;
    rem_d   = rem_q;
    store_d = store_q;
    err_d   = err_q;
    vl_d    = vl_q;
    base_d  = base_q;
    buf_d   = buf_q;
    vd_d    = vd_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = 2'd0;
          words_d = 3'((bytes_cap + 5'd3) >> 2);
          rem_d   = bytes_cap[1:0];
          store_d = store;
          vl_d    = vl;
          base_d  = base_addr;
          err_d   = 1'b0;
          // Same buffer serves as store source and load assembly area.
          buf_d   = store ? vs3_data : '0;
          if (vl == 5'd0) begin
            state_d = S_FIN;
          end else if (base_addr[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (data_gnt_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (data_rvalid_i) begin
          if (rsp_err) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            if (!store_q) begin
              for (int b = 0; b < 4; b++) begin
                if (be[b]) buf_d[{idx_q, 2'(b), 3'b000} +: 8] = data_rdata_i[8*b +: 8];
              end
            end
            idx_d = idx_q + 2'd1;
            if (last_word) state_d = store_q ? S_FIN : S_WB;
            else           state_d = S_REQ;
          end
        end
      end
      S_WB: begin
        vd_d    = buf_q;
        state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      words_q <= '0;
      rem_q   <= '0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
      vl_q    <= '0;
      base_q  <= '0;
      buf_q   <= '0;
      vd_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      words_q <= words_d;
      rem_q   <= rem_d;
      store_q <= store_d;
      err_q   <= err_d;
      vl_q    <= vl_d;
      base_q  <= base_d;
      buf_q   <= buf_d;
      vd_q    <= vd_d;
    end
  end

  // Outputs decode the registered state so an async reset clears them at once.
  logic in_req;
  logic in_wb;

  assign in_req            = (state_q == S_REQ);
  assign in_wb             = (state_q == S_WB);
  assign busy              = in_req || (state_q == S_WAIT) || in_wb;
  assign done              = (state_q == S_FIN);
  assign error             = done && err_q;
  assign vreg_write        = in_wb;
  assign elements_to_write = in_wb ? vl_q : 5'd0;
  assign vd_data           = in_wb ? buf_q : vd_q;
  assign data_req_o        = in_req;
  assign data_addr_o       = in_req ? (base_q + ADDR_WIDTH'({idx_q, 2'b00})) : '0;
  assign data_we_o         = in_req && store_q;
  assign data_be_o         = in_req ? be : 4'b0000;
  assign data_wdata_o      = in_req ? buf_q[{idx_q, 5'd0} +: 32] : 32'h0;

endmodule

// File: tb/tb_vector_lsu.sv
// tb_vector_lsu: self-checking bench for vector_lsu with a word-array memory and an OBI responder
// whose grant can be stalled per word. Expected bus traffic, register image and latency come from
// byte-level arithmetic on the request (bytes = min(vl << sew, 16)), not from the design's FSM.
module tb_vector_lsu;

  logic         clk = 1'b0;
  logic         n_reset;
  logic         start;
  logic         store;
  logic [31:0]  base_addr;
  logic [4:0]   vl;
  logic [1:0]   vsew;
  logic [127:0] vs3_data;
  logic         busy, done, error, vreg_write;
  logic [127:0] vd_data;
  logic [4:0]   elements_to_write;
  logic         data_req_o, data_gnt_i, data_we_o, data_rvalid_i;
  logic [31:0]  data_addr_o, data_wdata_o, data_rdata_i;
  logic [3:0]   data_be_o;
`ifdef VLSU_BUS_ERR_EN
  logic         data_err_i;
  int           err_word = -1;
`endif

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:255];

  // Observations of the most recent transaction.
  logic [31:0]  o_addr[$];
  logic         o_we[$];
  logic [3:0]   o_be[$];
  logic [31:0]  o_wdata[$];
  int           o_vw, o_done, o_lat, o_busy, o_unstable;
  logic         o_err, o_timeout, o_done_after;
  logic [127:0] o_vd;
  logic [4:0]   o_etw;

  vector_lsu #(.VLEN(128), .ADDR_WIDTH(32)) dut (
    .clk(clk), .n_reset(n_reset), .start(start), .store(store), .base_addr(base_addr),
    .vl(vl), .vsew(vsew), .vs3_data(vs3_data), .busy(busy), .done(done), .error(error),
    .vd_data(vd_data), .vreg_write(vreg_write), .elements_to_write(elements_to_write),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i),
`ifdef VLSU_BUS_ERR_EN
    .data_err_i(data_err_i),
`endif
    .data_rdata_i(data_rdata_i)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int exp_bytes(input logic [4:0] v, input logic [1:0] s);
    int sh = (s == 2'b11) ? 2 : int'(s);
    int b  = int'(v) * (1 << sh);
    return (b > 16) ? 16 : b;
  endfunction

  function automatic logic [3:0] exp_be(input int bytes, input int w);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (4*w + i < bytes);
    return r;
  endfunction

  function automatic logic [127:0] exp_vd(input logic [31:0] base, input int bytes);
    logic [127:0] r = '0;
    logic [31:0]  a, w;
    for (int k = 0; k < bytes; k++) begin
      a = base + k;
      w = mem[a[9:2]];
      r[8*k +: 8] = w[8*a[1:0] +: 8];
    end
    return r;
  endfunction

  // Edges counted from the edge that samples start to the edge after which done is seen.
  // Inclusive cycle count start..done is this plus one (e.g. 1 + 2*words + 2 for loads).
  function automatic int exp_lat(input logic st, input int words, input logic proceed, input int stalls);
    if (!proceed) return 1;
    return 2*words + (st ? 1 : 2) + stalls;
  endfunction

  // ---------------- driver / bus responder (collects observations only) ----------------
  task automatic run_txn(input logic st, input logic [31:0] base, input logic [4:0] vln,
                         input logic [1:0] sew, input logic [127:0] vs3,
                         input int stall_word, input int stall_cyc, input logic extra_start);
    int          edges, granted, stall_left;
    logic        rv_next, held;
    logic [31:0] rv_addr;
    logic [68:0] h_vec;
    o_addr.delete(); o_we.delete(); o_be.delete(); o_wdata.delete();
    o_vw = 0; o_done = 0; o_lat = -1; o_busy = 0; o_unstable = 0;
    o_err = 1'b0; o_vd = '0; o_etw = '0; o_timeout = 1'b1;
    stall_left = stall_cyc; granted = 0; rv_next = 1'b0; held = 1'b0; rv_addr = '0; h_vec = '0;
    store = st; base_addr = base; vl = vln; vsew = sew; vs3_data = vs3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; edges = 1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      data_rvalid_i = rv_next;
      data_rdata_i  = rv_next ? mem[rv_addr[9:2]] : 32'h0;
`ifdef VLSU_BUS_ERR_EN
      data_err_i    = rv_next && (granted - 1 == err_word);
`endif
      rv_next    = 1'b0;
      data_gnt_i = 1'b0;
      // A stray start while busy, with different parameters, must be ignored.
      start = extra_start && (edges == 2);
      if (start) begin
        store = ~st; base_addr = 32'h0000_0300; vl = 5'd16; vsew = 2'd0;
      end
      if (busy) o_busy++;
      if (vreg_write) begin
        o_vw++; o_vd = vd_data; o_etw = elements_to_write;
      end
      if (done) begin
        o_done++; o_err = error; o_lat = edges; o_timeout = 1'b0;
        break;
      end
      if (data_req_o) begin
        if (held && ({data_addr_o, data_we_o, data_be_o, data_wdata_o} !== h_vec)) o_unstable++;
        h_vec = {data_addr_o, data_we_o, data_be_o, data_wdata_o};
        held  = 1'b1;
        if (granted == stall_word && stall_left > 0) begin
          stall_left--;
        end else begin
          data_gnt_i = 1'b1;
          o_addr.push_back(data_addr_o); o_we.push_back(data_we_o);
          o_be.push_back(data_be_o);     o_wdata.push_back(data_wdata_o);
          granted++; rv_next = 1'b1; rv_addr = data_addr_o; held = 1'b0;
        end
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
`ifdef VLSU_BUS_ERR_EN
    data_err_i = 1'b0;
`endif
    @(posedge clk); #1;
    o_done_after = done;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_reset = 1'b0; start = 1'b0; store = 1'b0; base_addr = '0; vl = '0; vsew = '0; vs3_data = '0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
`ifdef VLSU_BUS_ERR_EN
    data_err_i = 1'b0;
`endif
    #3;
    checks++;
    if ({busy, done, error, vreg_write, data_req_o, data_we_o} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b want 000000", {busy, done, error, vreg_write, data_req_o, data_we_o});
    end
    checks++;
    if ({vd_data, elements_to_write, data_addr_o, data_be_o, data_wdata_o} !== '0) begin
      failures++; $display("FAIL reset_data: vd=%h etw=%0d addr=%h be=%b wdata=%h want all zero",
                           vd_data, elements_to_write, data_addr_o, data_be_o, data_wdata_o);
    end
    @(posedge clk); #1;
    n_reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_load_word();
    logic [127:0] want = 128'h44444444_33333333_22222222_11111111;
    mem[8'h40] = 32'h11111111; mem[8'h41] = 32'h22222222;
    mem[8'h42] = 32'h33333333; mem[8'h43] = 32'h44444444;
    run_txn(1'b0, 32'h100, 5'd4, 2'b10, '0, -1, 0, 1'b0);
    checks++;
    if (o_timeout || o_addr.size() != 4) begin
      failures++; $display("FAIL lw_count: reads=%0d timeout=%0d want 4/0", o_addr.size(), o_timeout);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (o_addr[i] !== 32'h100 + 4*i || o_be[i] !== 4'b1111 || o_we[i] !== 1'b0) begin
          failures++; $display("FAIL lw_bus[%0d]: addr=%h be=%b we=%b want %h 1111 0", i, o_addr[i], o_be[i], o_we[i], 32'h100 + 4*i);
        end
      end
    end
    checks++;
    if (o_vw != 1 || o_vd !== want || o_etw !== 5'd4) begin
      failures++; $display("FAIL lw_wb: writes=%0d vd=%h etw=%0d want 1 %h 4", o_vw, o_vd, o_etw, want);
    end
    checks++;
    if (o_lat != 10 || o_err !== 1'b0 || o_done_after !== 1'b0) begin
      failures++; $display("FAIL lw_timing: edges=%0d err=%b done_after=%b want 10 0 0", o_lat, o_err, o_done_after);
    end
    checks++;
    if (o_busy != 9) begin
      failures++; $display("FAIL lw_busy: busy_cycles=%0d want 9", o_busy);
    end
    checks++;
    if (vd_data !== want) begin
      failures++; $display("FAIL lw_vd_hold: got %h want %h", vd_data, want);
    end
  endtask

  task automatic test_load_byte();
    logic [127:0] want = 128'h000000DD_AABBCCDD;
    mem[8'h80] = 32'hAABBCCDD; mem[8'h81] = 32'hAABBCCDD;
    run_txn(1'b0, 32'h200, 5'd5, 2'b00, '0, -1, 0, 1'b0);
    checks++;
    if (o_addr.size() != 2) begin
      failures++; $display("FAIL lb_count: reads=%0d want 2", o_addr.size());
    end else begin
      checks++;
      if (o_be[0] !== 4'b1111 || o_be[1] !== 4'b0001 || o_addr[1] !== 32'h204) begin
        failures++; $display("FAIL lb_be: be0=%b be1=%b addr1=%h want 1111 0001 204", o_be[0], o_be[1], o_addr[1]);
      end
    end
    checks++;
    if (o_vw != 1 || o_vd !== want || o_etw !== 5'd5) begin
      failures++; $display("FAIL lb_wb: writes=%0d vd=%h etw=%0d want 1 %h 5", o_vw, o_vd, o_etw, want);
    end
  endtask

  task automatic test_store();
    run_txn(1'b1, 32'h300, 5'd3, 2'b01, 128'h0000_3333_2222_1111, -1, 0, 1'b0);
    checks++;
    if (o_addr.size() != 2) begin
      failures++; $display("FAIL st_count: writes=%0d want 2", o_addr.size());
    end else begin
      checks++;
      if (o_wdata[0] !== 32'h22221111 || o_be[0] !== 4'b1111 || o_we[0] !== 1'b1 || o_addr[0] !== 32'h300) begin
        failures++; $display("FAIL st_w0: addr=%h wdata=%h be=%b we=%b want 300 22221111 1111 1", o_addr[0], o_wdata[0], o_be[0], o_we[0]);
      end
      checks++;
      if (o_wdata[1] !== 32'h00003333 || o_be[1] !== 4'b0011 || o_we[1] !== 1'b1 || o_addr[1] !== 32'h304) begin
        failures++; $display("FAIL st_w1: addr=%h wdata=%h be=%b we=%b want 304 00003333 0011 1", o_addr[1], o_wdata[1], o_be[1], o_we[1]);
      end
    end
    checks++;
    if (o_vw != 0 || o_done != 1 || o_lat != 5) begin
      failures++; $display("FAIL st_end: vreg_writes=%0d done=%0d edges=%0d want 0 1 5", o_vw, o_done, o_lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] want = 128'h44444444_33333333_22222222_11111111;
    run_txn(1'b0, 32'h100, 5'd4, 2'b10, '0, 1, 3, 1'b1);
    checks++;
    if (o_unstable != 0) begin
      failures++; $display("FAIL stall_stable: changes=%0d want 0", o_unstable);
    end
    checks++;
    if (o_addr.size() != 4 || o_vd !== want || o_vw != 1 || o_lat != 13) begin
      failures++; $display("FAIL stall_result: reads=%0d vd=%h writes=%0d edges=%0d want 4 %h 1 13", o_addr.size(), o_vd, o_vw, o_lat, want);
    end
    // Idle check: the ignored start must not have queued a second transfer.
    checks++;
    if (busy !== 1'b0 || data_req_o !== 1'b0) begin
      failures++; $display("FAIL stall_no_restart: busy=%b req=%b want 0 0", busy, data_req_o);
    end
  endtask

  task automatic test_zero_vl_misaligned();
    run_txn(1'b0, 32'h100, 5'd0, 2'b10, '0, -1, 0, 1'b0);
    checks++;
    if (o_addr.size() != 0 || o_vw != 0 || o_done != 1 || o_err !== 1'b0 || o_lat != 1) begin
      failures++; $display("FAIL vl0: reqs=%0d writes=%0d done=%0d err=%b edges=%0d want 0 0 1 0 1", o_addr.size(), o_vw, o_done, o_err, o_lat);
    end
    run_txn(1'b1, 32'h102, 5'd4, 2'b10, '1, -1, 0, 1'b0);
    checks++;
    if (o_addr.size() != 0 || o_done != 1 || o_err !== 1'b1 || o_lat != 1) begin
      failures++; $display("FAIL misalign: reqs=%0d done=%0d err=%b edges=%0d want 0 1 1 1", o_addr.size(), o_done, o_err, o_lat);
    end
  endtask

  task automatic test_reset_midflight();
    int seen;
    store = 1'b0; base_addr = 32'h100; vl = 5'd4; vsew = 2'b10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (data_req_o !== 1'b1) begin
      failures++; $display("FAIL rst_pre_req: got %b want 1", data_req_o);
    end
    #2 n_reset = 1'b0;
    #1;
    checks++;
    if ({data_req_o, busy, vreg_write, done} !== 4'b0) begin
      failures++; $display("FAIL rst_async: req/busy/vw/done=%b want 0000", {data_req_o, busy, vreg_write, done});
    end
    @(posedge clk); #1;
    n_reset = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (done || vreg_write || data_req_o || busy) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL rst_quiet: active cycles=%0d want 0", seen);
    end
  endtask

`ifdef VLSU_BUS_ERR_EN
  task automatic test_bus_err();
    err_word = 1;
    run_txn(1'b0, 32'h100, 5'd4, 2'b10, '0, -1, 0, 1'b0);
    err_word = -1;
    checks++;
    if (o_addr.size() != 2 || o_vw != 0 || o_done != 1 || o_err !== 1'b1) begin
      failures++; $display("FAIL bus_err: reqs=%0d writes=%0d done=%0d err=%b want 2 0 1 1", o_addr.size(), o_vw, o_done, o_err);
    end
  endtask
`endif

  task automatic test_random();
    logic         st, proceed;
    logic [31:0]  base;
    logic [4:0]   vln;
    logic [1:0]   sew;
    logic [127:0] vs3, want;
    int           bytes, words, sw, sc, stalls;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int t = 0; t < 40; t++) begin
      st   = 1'($urandom_range(0, 1));
      sew  = 2'($urandom_range(0, 3));
      vln  = 5'($urandom_range(0, 16));
      base = {22'd0, 8'($urandom_range(0, 8'hC0)), 2'b00};
      if ($urandom_range(0, 7) == 0) base[1:0] = 2'($urandom_range(1, 3));
      vs3  = {$urandom, $urandom, $urandom, $urandom};
      sw   = $urandom_range(0, 3);
      sc   = $urandom_range(0, 2);
      run_txn(st, base, vln, sew, vs3, sw, sc, 1'b0);
      bytes   = exp_bytes(vln, sew);
      proceed = (vln != 0) && (base[1:0] == 2'b00);
      words   = proceed ? (bytes + 3) / 4 : 0;
      stalls  = (sw < words) ? sc : 0;
      want    = exp_vd(base, bytes);
      checks++;
      if (o_timeout || o_addr.size() != words) begin
        failures++; $display("FAIL rnd%0d_count: xfers=%0d timeout=%0d want %0d", t, o_addr.size(), o_timeout, words);
      end else begin
        for (int w = 0; w < words; w++) begin
          checks++;
          if (o_addr[w] !== base + 4*w || o_we[w] !== st || o_be[w] !== exp_be(bytes, w) ||
              (st && o_wdata[w] !== vs3[32*w +: 32])) begin
            failures++; $display("FAIL rnd%0d_bus[%0d]: addr=%h we=%b be=%b wdata=%h want %h %b %b %h", t, w,
                                 o_addr[w], o_we[w], o_be[w], o_wdata[w], base + 4*w, st, exp_be(bytes, w), vs3[32*w +: 32]);
          end
        end
      end
      checks++;
      if (o_vw != ((proceed && !st) ? 1 : 0) || ((proceed && !st) && (o_vd !== want || o_etw !== vln))) begin
        failures++; $display("FAIL rnd%0d_wb: writes=%0d vd=%h etw=%0d want vd=%h etw=%0d", t, o_vw, o_vd, o_etw, want, vln);
      end
      checks++;
      if (o_lat != exp_lat(st, words, proceed, stalls) || o_err !== ((vln != 0) && (base[1:0] != 2'b00)) ||
          o_unstable != 0 || o_done_after !== 1'b0) begin
        failures++; $display("FAIL rnd%0d_end: edges=%0d err=%b unstable=%0d done_after=%b want edges=%0d", t,
                             o_lat, o_err, o_unstable, o_done_after, exp_lat(st, words, proceed, stalls));
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_byte();
    test_store();
    test_back_to_back();
    test_zero_vl_misaligned();
    test_random();
    test_reset_midflight();
`ifdef VLSU_BUS_ERR_EN
    test_bus_err();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
